// File: rtl/cache_wbbuf_pkg.sv
// Shared types and default geometry for the victim write-back buffer.
// Optional feature macro (used by the other files): CACHE_WBBUF_FORWARD_EN.
package cache_wbbuf_pkg;

   // Default geometry used as parameter defaults by the buffer modules.
   localparam int ENTRIES_DEF = 2;
   localparam int PA_BITS_DEF = 32;
   localparam int LINELEN_DEF = 512;
   localparam int BEATLEN_DEF = 64;

   // Constants derived from the default geometry.
   localparam int BEATS      = LINELEN_DEF / BEATLEN_DEF;
   localparam int LOGBEATS   = $clog2(BEATS);
   localparam int OFFSETLEN  = $clog2(LINELEN_DEF / 8);
   localparam int LOGENTRIES = $clog2(ENTRIES_DEF);

   // Drain engine: waiting for a line, or streaming the head line as a burst.
   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } drain_state_t;

endpackage

// File: rtl/cache_wbbuf_match.sv
// Address lookup against the buffered lines: one comparator per entry,
// gated by the entry's valid bit. With CACHE_WBBUF_FORWARD_EN defined it
// also returns the line of the youngest matching entry (youngest counted
// backwards from the tail pointer).
module cache_wbbuf_match
   import cache_wbbuf_pkg::*;
#(
   parameter int ENTRIES = ENTRIES_DEF,
   parameter int PA_BITS = PA_BITS_DEF,
   parameter int LINELEN = LINELEN_DEF
) (
   input  logic [ENTRIES-1:0] valid,
   input  logic [PA_BITS-1:0] adrs [ENTRIES],
   input  logic [PA_BITS-1:0] lookup_adr,
   output logic               hit
`ifdef CACHE_WBBUF_FORWARD_EN
   ,
   input  logic [$clog2(ENTRIES)-1:0] tail,
   input  logic [LINELEN-1:0]         lines [ENTRIES],
   output logic [LINELEN-1:0]         data
`endif
);

   localparam int offset_len = $clog2(LINELEN / 8);
   localparam logic [PA_BITS-1:0] line_mask = {PA_BITS{1'b1}} << offset_len;

   logic [PA_BITS-1:0] key;
   logic [ENTRIES-1:0] match;

   // Stored addresses are already line aligned, so only the probe is masked.
   assign key = lookup_adr & line_mask;

   genvar gi;
   for (gi = 0; gi < ENTRIES; gi++) begin : g_cmp
      assign match[gi] = valid[gi] && (adrs[gi] == key);
   end

   assign hit = |match;

`ifdef CACHE_WBBUF_FORWARD_EN
   localparam int log_entries = $clog2(ENTRIES);

   logic [log_entries-1:0] idx;
   logic                   found;

   // Walk from the most recently written slot (tail-1) back to the oldest.
   always_comb begin
      data  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= ENTRIES; k++) begin
         idx = tail - log_entries'(k);
         if (!found && match[idx]) begin
            data  = lines[idx];
            found = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/cache_victim_wbbuf.sv
// Victim write-back buffer: a small FIFO of evicted dirty lines, drained to
// the bus one beat at a time, with an address lookup for refill hazards.
// Optional feature macro: CACHE_WBBUF_FORWARD_EN (adds LookupData forwarding).
module cache_victim_wbbuf
   import cache_wbbuf_pkg::*;
#(
   parameter int ENTRIES = ENTRIES_DEF,
   parameter int PA_BITS = PA_BITS_DEF,
   parameter int LINELEN = LINELEN_DEF,
   parameter int BEATLEN = BEATLEN_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               EvictValid,
   output logic               EvictReady,
   input  logic [PA_BITS-1:0] EvictAdr,
   input  logic [LINELEN-1:0] EvictLine,
   output logic               BusReq,
   output logic [PA_BITS-1:0] BusAdr,
   output logic [BEATLEN-1:0] BusWData,
   output logic               BusLast,
   input  logic               BusBeatAck,
   input  logic [PA_BITS-1:0] LookupAdr,
   output logic               LookupHit,
   output logic               Empty,
   output logic               Full
`ifdef CACHE_WBBUF_FORWARD_EN
   ,
   output logic [LINELEN-1:0] LookupData
`endif
);

   localparam int n_beats     = LINELEN / BEATLEN;
   localparam int log_beats   = $clog2(n_beats);
   localparam int log_entries = $clog2(ENTRIES);
   localparam int offset_len  = $clog2(LINELEN / 8);
   localparam int beat_shift  = $clog2(BEATLEN / 8);
   localparam logic [PA_BITS-1:0]   line_mask = {PA_BITS{1'b1}} << offset_len;
   localparam logic [log_beats-1:0] last_beat = log_beats'(n_beats - 1);

   drain_state_t           state_reg, state_next;
   logic [log_beats-1:0]   beat_reg, beat_next;
   logic [log_entries-1:0] head_reg, tail_reg;
   logic [ENTRIES-1:0]     valid_reg;
   logic [PA_BITS-1:0]     adr_mem  [ENTRIES];
   logic [LINELEN-1:0]     line_mem [ENTRIES];
   logic                   push, pop, bursting;

   assign Full       = &valid_reg;
   assign Empty      = ~|valid_reg;
   assign EvictReady = ~Full;

   // Readiness is judged on occupancy at the start of the cycle, so a full
   // buffer that pops this cycle still refuses the offered line.
   assign push     = EvictValid & ~Full;
   assign bursting = (state_reg == BURST);
   assign pop      = bursting & BusBeatAck & BusLast;

   // Line storage: written at the tail on a push, never reset.
   always_ff @(posedge clk) begin
      if (push) begin
         adr_mem[tail_reg]  <= EvictAdr & line_mask;
         line_mem[tail_reg] <= EvictLine;
      end
   end

   // Valid bits and FIFO pointers; push and pop may land in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg <= '0;
         head_reg  <= '0;
         tail_reg  <= '0;
      end else begin
         if (pop) begin
            valid_reg[head_reg] <= 1'b0;
            head_reg            <= head_reg + log_entries'(1);
         end
         if (push) begin
            valid_reg[tail_reg] <= 1'b1;
            tail_reg            <= tail_reg + log_entries'(1);
         end
      end
   end

   // Drain state and beat counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         beat_reg  <= '0;
      end else begin
         state_reg <= state_next;
         beat_reg  <= beat_next;
      end
   end

   // Next-state logic: every burst returns through IDLE, giving a one-cycle
   // bubble before the next line starts.
   always_comb begin
      state_next = state_reg;
      beat_next  = beat_reg;
      case (state_reg)
         IDLE: begin
            if (!Empty) begin
               state_next = BURST;
               beat_next  = '0;
            end
         end
         BURST: begin
            if (BusBeatAck) begin
               if (BusLast) begin
                  state_next = IDLE;
               end else begin
                  beat_next = beat_reg + log_beats'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Beat mux: address and data of the current beat of the head line,
   // forced to zero outside a burst.
   always_comb begin
      BusReq   = bursting;
      BusLast  = bursting && (beat_reg == last_beat);
      BusAdr   = '0;
      BusWData = '0;
      if (bursting) begin
         BusAdr   = adr_mem[head_reg] + (PA_BITS'(beat_reg) << beat_shift);
         BusWData = line_mem[head_reg][beat_reg * BEATLEN +: BEATLEN];
      end
   end

   cache_wbbuf_match #(
      .ENTRIES (ENTRIES),
      .PA_BITS (PA_BITS),
      .LINELEN (LINELEN)
   ) u_match (
      .valid      (valid_reg),
      .adrs       (adr_mem),
      .lookup_adr (LookupAdr),
      .hit        (LookupHit)
`ifdef CACHE_WBBUF_FORWARD_EN
      ,
      .tail       (tail_reg),
      .lines      (line_mem),
      .data       (LookupData)
`endif
   );

endmodule
